// File: rtl/vote_session_if.sv
// Handshake and result bus between the voter front end and vote_session_ctrl.
// master drives the voter/session controls, slave is the controller side.
interface vote_session_if;
    logic       start;
    logic       abort;
    logic [3:0] vote_valid;
    logic [3:0] vote_val;
    logic       res_ack;
    logic       busy;
    logic [3:0] voted;
    logic [2:0] yes_cnt;
    logic [2:0] result;
    logic       res_valid;
    logic       timed_out;

    modport master (
        output start, abort, vote_valid, vote_val, res_ack,
        input  busy, voted, yes_cnt, result, res_valid, timed_out
    );

    modport slave (
        input  start, abort, vote_valid, vote_val, res_ack,
        output busy, voted, yes_cnt, result, res_valid, timed_out
    );
endinterface

// File: rtl/vote_session_ctrl.sv
// Four-voter ballot sequencer: open window, latch first votes, tally, hold verdict until ack.
// Optional macro VOTE_TIE_RETRY_EN re-opens the window on a tie up to MAX_RETRY times.
module vote_session_ctrl #(
    parameter int TIMEOUT   = 100,
    parameter int TMR_W     = 16,
    parameter int MAX_RETRY = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    vote_session_if.slave  bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_OPEN   = 2'd1;
    localparam logic [1:0] ST_TALLY  = 2'd2;
    localparam logic [1:0] ST_RESULT = 2'd3;

    localparam logic [TMR_W-1:0] TIMEOUT_LD = TMR_W'(TIMEOUT);

    logic [1:0]       r_state;
    logic [TMR_W-1:0] r_timer;
    logic [3:0]       r_ballot;
    logic [3:0]       r_voted;
    logic             r_busy;
    logic [2:0]       r_yes_cnt;
    logic [2:0]       r_result;
    logic             r_res_valid;
    logic             r_timed_out;

    logic [3:0]       w_voted_upd;
    logic [3:0]       w_ballot_upd;
    logic             w_all_voted;
    logic             w_expire;
    logic [2:0]       w_yes_cnt;
    logic [2:0]       w_result;
    logic             w_retry_tie;

    // First vote wins: a voter's ballot bit is only written while its voted bit is clear.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_voter
            assign w_voted_upd[gi]  = r_voted[gi] | bus.vote_valid[gi];
            assign w_ballot_upd[gi] = (bus.vote_valid[gi] && !r_voted[gi]) ? bus.vote_val[gi]
                                                                             : r_ballot[gi];
        end
    endgenerate

    assign w_all_voted = &w_voted_upd;
    assign w_expire    = (r_timer <= TMR_W'(1));

    always_comb begin
        w_yes_cnt = 3'd0;
        for (int k = 0; k < 4; k++) begin
            w_yes_cnt = w_yes_cnt + {2'b00, r_ballot[k] & r_voted[k]};
        end
    end

    always_comb begin
        if (w_yes_cnt <= 3'd1) begin
            w_result = 3'b100;
        end else if (w_yes_cnt == 3'd2) begin
            w_result = 3'b010;
        end else begin
            w_result = 3'b001;
        end
    end

`ifdef VOTE_TIE_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    logic [RETRY_W-1:0] r_retry;

    assign w_retry_tie = (w_yes_cnt == 3'd2) && (r_retry < RETRY_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retry <= '0;
        end else if (r_state == ST_IDLE && bus.start) begin
            r_retry <= '0;
        end else if (r_state == ST_TALLY && !bus.abort && w_retry_tie) begin
            r_retry <= r_retry + RETRY_W'(1);
        end
    end
`else
    logic w_unused_cfg;

    // Keeps MAX_RETRY referenced when tie retries are compiled out.
    assign w_unused_cfg = (MAX_RETRY != 0);
    assign w_retry_tie  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_ballot    <= 4'b0000;
            r_voted     <= 4'b0000;
            r_busy      <= 1'b0;
            r_yes_cnt   <= 3'd0;
            r_result    <= 3'b000;
            r_res_valid <= 1'b0;
            r_timed_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state     <= ST_OPEN;
                        r_busy      <= 1'b1;
                        r_timer     <= TIMEOUT_LD;
                        r_voted     <= 4'b0000;
                        r_ballot    <= 4'b0000;
                        r_timed_out <= 1'b0;
                    end
                end
                ST_OPEN: begin
                    if (bus.abort) begin
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                        r_voted  <= 4'b0000;
                        r_ballot <= 4'b0000;
                    end else begin
                        r_voted  <= w_voted_upd;
                        r_ballot <= w_ballot_upd;
                        r_timer  <= r_timer - TMR_W'(1);
                        // All-voted wins over a timer expiring in the same cycle.
                        if (w_all_voted) begin
                            r_state     <= ST_TALLY;
                            r_timed_out <= 1'b0;
                        end else if (w_expire) begin
                            r_state     <= ST_TALLY;
                            r_timed_out <= 1'b1;
                        end
                    end
                end
                ST_TALLY: begin
                    if (bus.abort) begin
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                        r_voted  <= 4'b0000;
                        r_ballot <= 4'b0000;
                    end else if (w_retry_tie) begin
                        r_state  <= ST_OPEN;
                        r_timer  <= TIMEOUT_LD;
                        r_voted  <= 4'b0000;
                        r_ballot <= 4'b0000;
                    end else begin
                        r_state     <= ST_RESULT;
                        r_res_valid <= 1'b1;
                        r_yes_cnt   <= w_yes_cnt;
                        r_result    <= w_result;
                    end
                end
                default: begin
                    if (bus.res_ack) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_res_valid <= 1'b0;
                        r_result    <= 3'b000;
                        r_yes_cnt   <= 3'd0;
                    end
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.voted     = r_voted;
    assign bus.yes_cnt   = r_yes_cnt;
    assign bus.result    = r_result;
    assign bus.res_valid = r_res_valid;
    assign bus.timed_out = r_timed_out;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Randomized session bench for vote_session_ctrl with a set-based ballot reference model.
module tb_vote_session_ctrl;

    localparam int TIMEOUT   = 10;
    localparam int TMR_W     = 16;
    localparam int MAX_RETRY = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    vote_session_if bus ();

    vote_session_ctrl #(
        .TIMEOUT   (TIMEOUT),
        .TMR_W     (TMR_W),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] plan[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.vote_valid = 4'b0000;
        bus.vote_val   = 4'b0000;
        bus.res_ack    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"},      bus.busy,      0);
        check_eq({tag, "_voted"},     bus.voted,     0);
        check_eq({tag, "_yes_cnt"},   bus.yes_cnt,   0);
        check_eq({tag, "_result"},    bus.result,    0);
        check_eq({tag, "_res_valid"}, bus.res_valid, 0);
        check_eq({tag, "_timed_out"}, bus.timed_out, 0);
    endtask

    function automatic logic [2:0] verdict(input int yes);
        if (yes <= 1) return 3'b100;
        if (yes == 2) return 3'b010;
        return 3'b001;
    endfunction

    // abort_at: window cycle in which abort is raised (0 = never); density: random vote rate.
    task automatic run_session(input int sid, input int abort_at, input bit tally_abort,
                               input int density, input bit ack_with_start);
        logic [3:0] m_voted;
        logic [3:0] m_ballot;
        logic [3:0] vv;
        logic [3:0] vl;
        logic [2:0] exp_res;
        int retries;
        int yes;
        bit closed;
        bit aborted;
        bit m_to;
        retries = 0;
        aborted = 1'b0;
        m_to    = 1'b0;
        m_voted = 4'b0000;
        m_ballot = 4'b0000;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check_eq("busy_open", bus.busy, 1);
        forever begin
            m_voted  = 4'b0000;
            m_ballot = 4'b0000;
            closed   = 1'b0;
            check_eq("voted_clear", bus.voted, 0);
            for (int c = 1; c <= TIMEOUT && !closed; c++) begin
                if (plan.size() > 0) begin
                    {vv, vl} = plan.pop_front();
                end else begin
                    vl = 4'($urandom);
                    if (density == 0)      vv = 4'b0000;
                    else if (density == 1) vv = 4'($urandom & $urandom & $urandom);
                    else                   vv = 4'($urandom & $urandom);
                end
                bus.vote_valid = vv;
                bus.vote_val   = vl;
                bus.abort      = (c == abort_at);
                step();
                if (c == abort_at) begin
                    aborted = 1'b1;
                    closed  = 1'b1;
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if (vv[i] && !m_voted[i]) begin
                            m_voted[i]  = 1'b1;
                            m_ballot[i] = vl[i];
                        end
                    end
                    check_eq("voted", bus.voted, m_voted);
                    check_eq("res_valid_open", bus.res_valid, 0);
                    if (m_voted == 4'hF) begin
                        closed = 1'b1;
                        m_to   = 1'b0;
                    end else if (c == TIMEOUT) begin
                        closed = 1'b1;
                        m_to   = 1'b1;
                    end
                end
            end
            drive_idle();
            if (aborted) break;
            // Controller now sits in its one-cycle tally; stray votes must be ignored.
            check_eq("res_valid_tally", bus.res_valid, 0);
            check_eq("busy_tally", bus.busy, 1);
            yes = $countones(m_ballot);
            exp_res = verdict(yes);
`ifdef VOTE_TIE_RETRY_EN
            if (yes == 2 && retries < MAX_RETRY && !tally_abort) begin
                retries++;
                bus.vote_valid = 4'($urandom);
                bus.vote_val   = 4'($urandom);
                step();
                drive_idle();
                check_eq("busy_retry", bus.busy, 1);
                continue;
            end
`endif
            if (tally_abort) begin
                bus.abort = 1'b1;
                step();
                drive_idle();
                aborted = 1'b1;
                break;
            end
            bus.vote_valid = 4'($urandom);
            bus.vote_val   = 4'($urandom);
            step();
            drive_idle();
            break;
        end

        if (aborted) begin
            check_eq("abort_busy", bus.busy, 0);
            check_eq("abort_voted", bus.voted, 0);
            check_eq("abort_res_valid", bus.res_valid, 0);
            step();
            check_eq("abort_no_result", bus.res_valid, 0);
            $display("session %0d: aborted", sid);
            return;
        end

        check_eq("res_valid", bus.res_valid, 1);
        check_eq("result", bus.result, exp_res);
        check_eq("yes_cnt", bus.yes_cnt, yes);
        check_eq("timed_out", bus.timed_out, m_to);
        check_eq("voted_result", bus.voted, m_voted);
        for (int h = $urandom_range(0, 3); h > 0; h--) begin
            bus.start      = 1'($urandom);
            bus.abort      = 1'($urandom);
            bus.vote_valid = 4'($urandom);
            bus.vote_val   = 4'($urandom);
            step();
            drive_idle();
            check_eq("hold_res_valid", bus.res_valid, 1);
            check_eq("hold_result", bus.result, exp_res);
            check_eq("hold_yes_cnt", bus.yes_cnt, yes);
        end
        bus.res_ack = 1'b1;
        bus.start   = ack_with_start;
        step();
        drive_idle();
        check_eq("ack_res_valid", bus.res_valid, 0);
        check_eq("ack_result", bus.result, 0);
        check_eq("ack_yes_cnt", bus.yes_cnt, 0);
        check_eq("ack_busy", bus.busy, 0);
        step();
        check_eq("idle_after_ack", bus.busy, 0);
        $display("session %0d: yes=%0d result=%b timed_out=%0d voted=%b retries=%0d",
                 sid, yes, exp_res, m_to, m_voted, retries);
    endtask

    initial begin
        drive_idle();
        rst_n = 1'b0;
        #12;
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Asynchronous reset in the middle of an open window.
        bus.start = 1'b1;
        step();
        bus.start      = 1'b0;
        bus.vote_valid = 4'b0011;
        bus.vote_val   = 4'b0001;
        step();
        drive_idle();
        check_eq("pre_reset_voted", bus.voted, 4'b0011);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check_all_zero("post_reset");

        plan = {{4'b1111, 4'b1011}};
        run_session(1, 0, 1'b0, 0, 1'b0);

        plan = {8'h00, 8'h00, {4'b0001, 4'b0001}};
        run_session(2, 0, 1'b0, 0, 1'b0);

        plan = {{4'b0100, 4'b0100}, 8'h00, {4'b0100, 4'b0000}, {4'b1011, 4'b0000}};
        run_session(3, 0, 1'b0, 0, 1'b1);

        plan = {{4'b0111, 4'b0101}, {4'b1000, 4'b0000}};
        run_session(4, 2, 1'b0, 0, 1'b0);

        plan = {{4'b1111, 4'b0011}};
        run_session(5, 0, 1'b1, 0, 1'b0);

        plan = {{4'b1111, 4'b0011}, {4'b1111, 4'b0011}, {4'b1111, 4'b0011}};
        run_session(6, 0, 1'b0, 0, 1'b0);

        plan = {{4'b1111, 4'b0011}, {4'b1111, 4'b0111}};
        run_session(7, 0, 1'b0, 0, 1'b0);
        plan.delete();

        for (int s = 0; s < 40; s++) begin
            run_session(10 + s,
                        ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, TIMEOUT)) : 0,
                        ($urandom_range(0, 19) == 0),
                        int'($urandom_range(1, 2)),
                        1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
